// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Provides the FSM state encoding and the counter sizing function.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor_fs_bl.sv
// Combinational 1-bit full subtractor: diff = ip1 - ip2 - ip3.
// Subtract-direction counterpart of the behavioural adder cell.
module fs_bl (
    input  logic ip1,
    input  logic ip2,
    input  logic ip3,
    output logic borrow,
    output logic diff
);
    assign diff   = ip1 ^ ip2 ^ ip3;
    assign borrow = (~ip1 & ip2) | (~(ip1 ^ ip2) & ip3);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor, LSB first, one bit per clock.
// One full-subtractor cell plus a registered borrow; result is published on DONE.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

    fs_bl u_fs (
        .ip1    (a_sh[0]),
        .ip2    (b_sh[0]),
        .ip3    (bin),
        .borrow (bout),
        .diff   (d)
    );

    assign last = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                // Back-to-back request is taken here without an idle bubble.
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bin      <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            bin  <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {d, r_sh[WIDTH-1:1]};
            bin  <= bout;
            cnt  <= cnt + 1'b1;
            if (last) begin
                diff_q   <= {d, r_sh[WIDTH-1:1]};
                borrow_q <= bout;
            end
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH 8 and 5).
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(5)) bus5 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One complete WIDTH=8 operation: latency, busy length and result.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] ed;
        int k;
        int bz;
        ed = a - b;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b;
        @(negedge clk);
        bus8.start = 1'b0;
        bz = bus8.busy ? 1 : 0;
        k  = 0;
        while (bus8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (bus8.busy === 1'b1) bz++;
        end
        chk({tag, " latency"}, k, 8);
        chk({tag, " busy_cycles"}, bz, 8);
        chk({tag, " diff"}, bus8.diff, ed);
        chk({tag, " borrow"}, bus8.borrow, (a < b) ? 1 : 0);
    endtask

    task automatic op5(input logic [4:0] a, input logic [4:0] b, input string tag);
        logic [4:0] ed;
        int k;
        ed = a - b;
        @(negedge clk);
        bus5.start = 1'b1; bus5.a = a; bus5.b = b;
        @(negedge clk);
        bus5.start = 1'b0;
        k = 0;
        while (bus5.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, 5);
        chk({tag, " diff"}, bus5.diff, ed);
        chk({tag, " borrow"}, bus5.borrow, (a < b) ? 1 : 0);
    endtask

    initial begin
        int k;
        int n;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus5.start = 1'b0; bus5.a = '0; bus5.b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", bus8.busy, 0);
        chk("reset done", bus8.done, 0);
        chk("reset diff", bus8.diff, 0);
        chk("reset borrow", bus8.borrow, 0);
        rst = 1'b0;

        op8(8'd200, 8'd55,  "basic");
        op8(8'd5,   8'd9,   "underflow");
        op8(8'd0,   8'd255, "zero_minus_max");
        op8(8'hA5,  8'hA5,  "equal");
        op8(8'h80,  8'h00,  "identity");

        // Start while busy must be dropped; result of the first request only.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd10; bus8.b = 8'd3;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold diff during shift", bus8.diff, 8'h80);
        bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2;
        @(negedge clk);
        bus8.start = 1'b0;
        k = 0;
        while (bus8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ignored diff", bus8.diff, 7);
        chk("ignored borrow", bus8.borrow, 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done === 1'b1) n++;
        end
        chk("ignored extra done", n, 0);

        // Start held through DONE: next op accepted on the DONE edge.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd20; bus8.b = 8'd7;
        k = 0;
        while (bus8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b first diff", bus8.diff, 13);
        bus8.a = 8'd50; bus8.b = 8'd60;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("b2b no bubble busy", bus8.busy, 1);
        chk("b2b no bubble done", bus8.done, 0);
        k = 0;
        while (bus8.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b second latency", k, 8);
        chk("b2b second diff", bus8.diff, 246);
        chk("b2b second borrow", bus8.borrow, 1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd100; bus8.b = 8'd1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", bus8.busy, 0);
        chk("midrst done", bus8.done, 0);
        chk("midrst diff", bus8.diff, 0);
        chk("midrst borrow", bus8.borrow, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done === 1'b1) n++;
        end
        chk("midrst no done", n, 0);
        op8(8'd9, 8'd4, "after_reset");

        for (int i = 0; i < 1000; i++)
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand8");
        for (int i = 0; i < 1000; i++)
            op5(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit unsigned subtractor computing diff = a - b, processing one bit per clock, LSB first.
- Built around a single full-subtractor cell plus a registered borrow.
- It is the subtract-direction companion of the team's behavioural full adder, intended for area-lean datapaths where latency is acceptable.
- A start/busy/done handshake sequences each operation.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  registered difference, a - b mod 2^WIDTH.
- borrow  output  1  registered final borrow-out; 1 means a < b.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE
  - busy = 0, done = 0, diff = 0, borrow = 0
  - internal shift registers, counter and borrow flop cleared
  - any in-flight operation is discarded; no done is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start = 1: load a_sh = a, b_sh = b, bin = 0, cnt = 0, busy = 1; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - Full-subtractor cell on x = a_sh[0], y = b_sh[0], bin.
  - d = x ^ y ^ bin.
  - bout = (~x & y) | (~(x ^ y) & bin).
  - a_sh and b_sh shift right by 1.
  - d is shifted into the MSB of the result shift register.
  - bin <= bout; cnt <= cnt + 1.
- SHIFT exit:
  - On the edge where cnt == WIDTH-1, go to DONE.
  - On that edge diff <= final shifted result, borrow <= bout, busy <= 0, done <= 1.
- DONE (one cycle):
  - done = 1.
  - On the next edge done <= 0.
  - If start = 1 on that edge, the new operands are accepted exactly as from IDLE (back-to-back ops, no bubble); otherwise go to IDLE.
- Latency:
  - Start sampled on edge E0; done is high in the cycle following edge E(WIDTH).
  - Throughput: one result per WIDTH+1 cycles.
- start while busy (SHIFT) is ignored; operands on a/b are not re-sampled.
- diff and borrow hold their last result until the next DONE transition. They do not change during SHIFT.
- Counter width $clog2(WIDTH); it must not wrap before WIDTH-1 is reached.
- Wrap-around: a < b yields the two's-complement modular result, with borrow = 1.
- a == b yields diff = 0, borrow = 0.
- No X propagation: all registers are reset.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/SHIFT/DONE, 2-bit encoding).
  - constant for the counter-width function.
- One sub-module: fs_bl, a combinational 1-bit full subtractor.
  - Inputs: ip1 (x), ip2 (y), ip3 (bin).
  - Outputs: borrow, diff.
  - Mirrors the adder cell and is reusable in future ripple subtractors.
- The top level contains the FSM, shift registers, counter and borrow flop.

Test Plan:
- Basic subtract: WIDTH=8, a=200, b=55, one-cycle start pulse -> done pulses exactly 8 clocks after the start edge; diff=145, borrow=0; busy high for 8 cycles.
- Underflow: a=5, b=9 -> diff=252 (0xFC), borrow=1. Also a=0, b=255 -> diff=1, borrow=1.
- Equal and identity: a=b=0xA5 -> diff=0, borrow=0. Also a=0x80, b=0 -> diff=0x80, borrow=0.
- Start ignored while busy:
  - start a=10, b=3; at cycle 3 assert start with a=1, b=2.
  - Required: only one done, with diff=7, borrow=0; second request dropped.
  - Back-to-back: start held high through DONE -> next op accepted with no idle cycle.
- Reset mid-operation:
  - start a=100, b=1; assert rst asynchronously at cycle 4, between edges.
  - Required: busy/done/diff/borrow go to 0 immediately, with no done afterwards.
  - A subsequent a=9, b=4 completes with diff=5.
- Randomized self-check (WIDTH=8 and WIDTH=5): 1000 random operand pairs vs. reference (a - b) mod 2^WIDTH and borrow = (a < b).
